// File: rtl/wb_conbus_rr.sv
`default_nettype none
// ==========================================================================
// Module   : wb_conbus_rr
// Purpose  : Wishbone shared bus with round-robin arbiter, tag decode, watchdog
// Revision : 1.0
// ==========================================================================
module wb_conbus_rr #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int SEL_WIDTH      = 2,
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 8,
  parameter int S_ADDR_W       = 4,
  parameter logic [NUM_SLAVES*S_ADDR_W-1:0] SLAVE_BASE = {(NUM_SLAVES*S_ADDR_W){1'bx}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_dat_i,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_dat_o,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]  s_adr_o,
  output logic [NUM_SLAVES*3-1:0]           s_cti_o,
  output logic [NUM_SLAVES*SEL_WIDTH-1:0]   s_sel_o,
  output logic [NUM_SLAVES-1:0]             s_we_o,
  output logic [NUM_SLAVES-1:0]             s_cyc_o,
  output logic [NUM_SLAVES-1:0]             s_stb_o,
  input  logic [NUM_SLAVES-1:0]             s_ack_i
);

  localparam int GNT_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WDOG_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GNT_IDX_W-1:0] LAST_RST = GNT_IDX_W'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [GNT_IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [ADDR_WIDTH-1:0]  w_adr;
  logic [DATA_WIDTH-1:0]  w_wdat;
  logic [DATA_WIDTH-1:0]  w_rdat;
  logic [2:0]             w_cti;
  logic [SEL_WIDTH-1:0]   w_sel;
  logic [S_ADDR_W-1:0]    w_tag;
  logic [NUM_SLAVES-1:0]  w_hit;
  logic                   w_cyc, w_stb, w_we, w_req, w_mapped, w_ack, w_gnt_chg;

  // Shared bus: AND-OR select of the granted master's fields.
  always_comb begin
    w_adr  = '0;
    w_wdat = '0;
    w_cti  = '0;
    w_sel  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      w_adr  = w_adr  | (m_adr_i[m*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt_q[m]}});
      w_wdat = w_wdat | (m_dat_i[m*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_q[m]}});
      w_cti  = w_cti  | (m_cti_i[m*3 +: 3] & {3{gnt_q[m]}});
      w_sel  = w_sel  | (m_sel_i[m*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{gnt_q[m]}});
    end
  end

  assign w_cyc = |(gnt_q & m_cyc_i);
  assign w_stb = |(gnt_q & m_stb_i);
  assign w_we  = |(gnt_q & m_we_i);
  assign w_req = w_cyc & w_stb;

  // Round-robin: scan distances from the far end so the nearest requester wins.
  always_comb begin
    gnt_d  = gnt_q;
    last_d = last_q;
    if (!w_cyc) begin
      gnt_d = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
          if (m_cyc_i[m] && ((int'(last_q) + 1 + k == m) ||
                             (int'(last_q) + 1 + k == m + NUM_MASTERS))) begin
            gnt_d    = '0;
            gnt_d[m] = 1'b1;
            last_d   = GNT_IDX_W'(m);
          end
        end
      end
    end
  end

  assign w_gnt_chg = (gnt_d != gnt_q);

  // Address decode; descending scan lets the lowest matching slot win.
  assign w_tag = w_adr[ADDR_WIDTH-1 -: S_ADDR_W];

  always_comb begin
    w_hit = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if (w_tag == SLAVE_BASE[s*S_ADDR_W +: S_ADDR_W]) begin
        w_hit    = '0;
        w_hit[s] = 1'b1;
      end
    end
  end

  assign w_mapped = |w_hit;

  always_comb begin
    w_rdat = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_rdat = w_rdat | (s_dat_i[s*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_hit[s]}});
    end
    w_rdat = w_rdat & {DATA_WIDTH{|gnt_q}};
  end

  // An ack arriving while the error is being reported belongs to an aborted transfer.
  assign w_ack = |(s_ack_i & w_hit) & ~err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (!WDOG_EN || err_q || !w_req || !w_mapped || w_ack || w_gnt_chg) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!err_q && w_req && !w_mapped) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt_q  <= '0;
      last_q <= LAST_RST;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign m_dat_o = {NUM_MASTERS{w_rdat}};
  assign m_ack_o = gnt_q & {NUM_MASTERS{w_ack}};
  assign m_err_o = gnt_q & {NUM_MASTERS{err_q}};

  assign s_dat_o = {NUM_SLAVES{w_wdat}};
  assign s_adr_o = {NUM_SLAVES{w_adr}};
  assign s_cti_o = {NUM_SLAVES{w_cti}};
  assign s_sel_o = {NUM_SLAVES{w_sel}};
  assign s_we_o  = {NUM_SLAVES{w_we}};
  assign s_cyc_o = {NUM_SLAVES{w_cyc}};
  assign s_stb_o = w_hit & {NUM_SLAVES{w_req & ~err_q}};

endmodule
`default_nettype wire
